multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multi-cycle RV32I core; sits directly upstream of the ALU control decoder and drives its 2-bit `aluop` input. It also sequences the datapath muxes, register-file writes, PC/IR writes and memory strobes. It steps each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory ready handshake.

## Interface
- Parameters: none.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `opcode` in 7: IR[6:0], valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `pc_write` out 1: PC register write enable.
- `ir_write` out 1: IR write enable; the datapath also latches old_pc on it.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: writeback select. 00 ALUOut, 01 MDR, 10 PC.
- `alu_src_a` out 2: ALU A select. 00 PC, 01 old_pc, 10 rs1 register.
- `alu_src_b` out 2: ALU B select. 00 rs2 register, 01 constant 4, 10 immediate.
- `aluop` out 2: to ALU control. 00 add, 01 sub, 10 decode from funct fields.
- `pc_source` out 1: PC input select. 0 = live ALU result, 1 = ALUOut.
- `illegal_instr` out 1: one-cycle pulse on an unsupported opcode.
- `state_out` out 4: current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10. Encodings 11–15 are unreachable and return to FETCH.
- Outputs are decoded combinationally from state; the only input-dependent terms are listed per state. Any output not listed is 0.
- FETCH:
  - mem_read=1, alu_src_a=00, alu_src_b=01, aluop=00, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=01, alu_src_b=10, aluop=00, so ALUOut = branch/jump target.
  - Next state by opcode: 0000011 or 0100011 → MEMADDR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL.
  - Any other opcode → FETCH with illegal_instr=1.
- MEMADDR: alu_src_a=10, alu_src_b=10, aluop=00. Load opcode → MEMREAD; otherwise → MEMWRITE.
- MEMREAD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then → MEMWB.
- MEMWB: reg_write=1, result_src=01, → FETCH.
- MEMWRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then → FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, aluop=10, → ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=10, aluop=00, → ALUWB.
- ALUWB: reg_write=1, result_src=00, → FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, aluop=01, pc_source=1, pc_write=zero, → FETCH.
- JAL: pc_write=1, pc_source=1, reg_write=1, result_src=10 (PC already holds old_pc+4), → FETCH.

## Timing
- Reset:
  - While reset=1, state is FETCH and every output is 0, including mem_read and state_out=0.
  - The first fetch begins on the first rising edge after reset deasserts.
- Reset mid-instruction:
  - The state returns to FETCH immediately, without waiting for a clock edge.
  - Pending write strobes drop in the same cycle, and no partial writeback occurs.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE and ignored in all other states. Wait time is unbounded, and outputs hold stable while waiting.
- Cycles per instruction, with mem_ready=1 on the first access cycle:
  - load 5, store 4, R-type 4, I-type 4, branch 3, jal 3.
  - Illegal opcode takes 2 cycles and re-fetches at the next PC.
- Each memory wait cycle adds exactly one cycle.
- Across a full instruction, pc_write is asserted at most twice: once in FETCH and once in BRANCH or JAL.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1:
  - All outputs are 0 during reset.
  - Cycle 1 is FETCH with mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- R-type (opcode 0110011):
  - States follow 0→1→6→8→0.
  - aluop=10 in EXEC_R; reg_write=1 only in ALUWB.
- Load with mem_ready low for 2 cycles in MEMREAD:
  - States follow 0,1,2,3,3,3,4,0.
  - mem_read and i_or_d stay high across all three MEMREAD cycles.
- Branch (1100011):
  - With zero=1, pc_write=1 and pc_source=1 in BRANCH.
  - With zero=0, pc_write=0.
  - Both cases take 3 cycles.
- Opcode 1111111:
  - illegal_instr pulses 1 in DECODE, then the FSM returns to FETCH.
  - reg_write, mem_write and pc_write stay 0 after FETCH.
- Reset asserted asynchronously mid-MEMWRITE:
  - mem_write drops without waiting for a clock edge.
  - state_out reads 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: steps fetch/decode/execute/memory/writeback
// and stalls on mem_ready. Outputs decode from state; all outputs are forced low during reset.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       pc_source,
    output logic       illegal_instr,
    output logic [3:0] state_out
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= MEMADDR;
                        OP_RTYPE:          state <= EXEC_R;
                        OP_ITYPE:          state <= EXEC_I;
                        OP_BRANCH:         state <= BRANCH;
                        OP_JAL:            state <= JAL;
                        default:           state <= FETCH;
                    endcase
                end
                MEMADDR:  state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXEC_R:   state <= ALUWB;
                EXEC_I:   state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    // Gating on reset keeps strobes low even though FETCH itself asserts mem_read.
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        aluop         = 2'b00;
        pc_source     = 1'b0;
        illegal_instr = 1'b0;
        state_out     = reset ? 4'd0 : state;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: illegal_instr = 1'b0;
                        default: illegal_instr = 1'b1;
                    endcase
                end
                MEMADDR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                MEMREAD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                end
                MEMWRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b00;
                    aluop     = 2'b10;
                end
                EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 2'b10;
                    aluop     = 2'b01;
                    pc_source = 1'b1;
                    pc_write  = zero;
                end
                JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule
